// File: rtl/psum_collector_if.sv
// ============================================================================
// Module      : psum_collector_if
// Description : Bundle of the MAC-array psum stream and the row-pop handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface psum_collector_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_err;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready, o_err
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready, o_err
  );
endinterface

`default_nettype wire

// File: rtl/psum_collector.sv
// ============================================================================
// Module      : psum_collector
// Description : Per-column FWFT FIFOs that absorb skewed psum writes and pop whole rows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  wire logic        clk,
  input  wire logic        reset,
  psum_collector_if.slave  bus
);

  localparam int c_addr_w = $clog2(depth);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(depth);

  logic [col-1:0] w_nonempty;
  logic [col-1:0] w_full;
  logic [col-1:0] w_push;
  logic [col-1:0] w_ovf;
  logic           w_valid;
  logic           w_pop;
  logic           w_underflow;
  logic           r_err;

  assign w_valid     = &w_nonempty;
  assign w_pop       = bus.rd & w_valid;
  assign w_underflow = bus.rd & ~w_valid;

  for (genvar c = 0; c < col; c++) begin : g_lane
    logic [psum_bw-1:0]  r_mem [depth];
    logic [c_addr_w-1:0] r_wptr;
    logic [c_addr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0]  r_count;

    assign w_nonempty[c] = (r_count != '0);
    assign w_full[c]     = (r_count == c_depth_cnt);
    // A pop in the same edge frees the slot, so a full lane may still accept.
    assign w_push[c]     = bus.wr[c] & (~w_full[c] | w_pop);
    assign w_ovf[c]      = bus.wr[c] & w_full[c] & ~w_pop;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[c]) r_wptr <= r_wptr + 1'b1;
        if (w_pop)     r_rptr <= r_rptr + 1'b1;
        case ({w_push[c], w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[c]) r_mem[r_wptr] <= bus.in[c*psum_bw +: psum_bw];
    end

    assign bus.out[c*psum_bw +: psum_bw] = r_mem[r_rptr];
  end

  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= r_err | (|w_ovf) | w_underflow;
  end

  assign bus.o_valid = w_valid;
  assign bus.o_full  = |w_full;
  assign bus.o_ready = ~(|w_full);
  assign bus.o_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_psum_collector.sv
// ============================================================================
// Module      : tb_psum_collector
// Description : Directed self-checking bench for psum_collector (col=8, depth=64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_collector;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  psum_collector_if #(.col(COL), .psum_bw(BW)) bus ();

  psum_collector #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane c of row r in stream s: distinct, easy to read in hex.
  function automatic logic [BW*COL-1:0] mk_row(input int r, input int s);
    logic [BW*COL-1:0] v;
    for (int c = 0; c < COL; c++) v[c*BW +: BW] = 16'((s << 12) + (r << 4) + c);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [COL-1:0] w, input logic [BW*COL-1:0] d, input logic r);
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(8'hFF, mk_row(0, 1), 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({bus.o_valid, bus.o_full, bus.o_ready, bus.o_err} !== 4'b0010) begin
        n_bad++;
        $display("FAIL reset_flags cyc%0d: got v/f/r/e=%b required 0010", i,
                 {bus.o_valid, bus.o_full, bus.o_ready, bus.o_err});
      end
    end
    reset = 1'b0;
    drive('0, '0, 1'b0);
  endtask

  task automatic test_skewed_fill();
    logic [BW*COL-1:0] exp_row;
    logic [BW*COL-1:0] d;
    for (int c = 0; c < COL; c++) exp_row[c*BW +: BW] = 16'h0100 + 16'(c);
    for (int c = 0; c < COL; c++) begin
      d = '0;
      d[c*BW +: BW] = 16'h0100 + 16'(c);
      drive(8'(1 << c), d, 1'b0);
      tick();
      n_cmp++;
      if (bus.o_valid !== (c == COL - 1)) begin
        n_bad++;
        $display("FAIL skew_valid lane%0d: got %b required %b", c, bus.o_valid, (c == COL - 1));
      end
    end
    drive('0, '0, 1'b0);
    n_cmp++;
    if (bus.out !== exp_row) begin
      n_bad++;
      $display("FAIL skew_row: got %h required %h", bus.out, exp_row);
    end
    drive('0, '0, 1'b1);
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_valid, bus.o_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL skew_drain: got valid/err=%b required 00", {bus.o_valid, bus.o_err});
    end
  endtask

  task automatic test_fill_capacity();
    for (int r = 0; r < DEP; r++) begin
      drive(8'hFF, mk_row(r, 1), 1'b0);
      tick();
    end
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_valid, bus.o_full, bus.o_ready, bus.o_err} !== 4'b1100) begin
      n_bad++;
      $display("FAIL cap_full: got v/f/r/e=%b required 1100",
               {bus.o_valid, bus.o_full, bus.o_ready, bus.o_err});
    end
    drive(8'hFF, mk_row(99, 15), 1'b0);
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_full, bus.o_err} !== 2'b11) begin
      n_bad++;
      $display("FAIL cap_overflow: got full/err=%b required 11", {bus.o_full, bus.o_err});
    end
    for (int r = 0; r < DEP; r++) begin
      n_cmp++;
      if (bus.out !== mk_row(r, 1) || bus.o_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL cap_pop row%0d: got %h valid %b required %h valid 1",
                 r, bus.out, bus.o_valid, mk_row(r, 1));
      end
      drive('0, '0, 1'b1);
      tick();
    end
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_valid, bus.o_full} !== 2'b00) begin
      n_bad++;
      $display("FAIL cap_empty: got valid/full=%b required 00", {bus.o_valid, bus.o_full});
    end
    do_reset();
    n_cmp++;
    if (bus.o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL cap_err_clear: got %b required 0", bus.o_err);
    end
  endtask

  task automatic test_full_concurrent();
    for (int r = 0; r < DEP; r++) begin
      drive(8'hFF, mk_row(r, 2), 1'b0);
      tick();
    end
    drive(8'hFF, mk_row(0, 3), 1'b1);
    n_cmp++;
    if (bus.out !== mk_row(0, 2)) begin
      n_bad++;
      $display("FAIL conc_head: got %h required %h", bus.out, mk_row(0, 2));
    end
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_full, bus.o_err} !== 2'b10) begin
      n_bad++;
      $display("FAIL conc_flags: got full/err=%b required 10", {bus.o_full, bus.o_err});
    end
    for (int k = 1; k <= DEP; k++) begin
      n_cmp++;
      if (bus.out !== ((k < DEP) ? mk_row(k, 2) : mk_row(0, 3))) begin
        n_bad++;
        $display("FAIL conc_pop %0d: got %h required %h", k, bus.out,
                 (k < DEP) ? mk_row(k, 2) : mk_row(0, 3));
      end
      drive('0, '0, 1'b1);
      tick();
    end
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_valid, bus.o_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL conc_end: got valid/err=%b required 00", {bus.o_valid, bus.o_err});
    end
  endtask

  task automatic test_underflow();
    drive('0, '0, 1'b1);
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_valid, bus.o_err} !== 2'b01) begin
      n_bad++;
      $display("FAIL uflow_flags: got valid/err=%b required 01", {bus.o_valid, bus.o_err});
    end
    drive(8'hFF, mk_row(5, 4), 1'b0);
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if (bus.out !== mk_row(5, 4) || bus.o_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL uflow_recover: got %h valid %b required %h valid 1",
               bus.out, bus.o_valid, mk_row(5, 4));
    end
    drive('0, '0, 1'b1);
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if (bus.o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL uflow_drain: got valid %b required 0", bus.o_valid);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    drive(8'hFF, mk_row(0, 5), 1'b0);
    tick();
    drive(8'hFF, mk_row(1, 5), 1'b1);
    n_cmp++;
    if (bus.out !== mk_row(0, 5)) begin
      n_bad++;
      $display("FAIL b2b_old_head: got %h required %h", bus.out, mk_row(0, 5));
    end
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if (bus.out !== mk_row(1, 5) || bus.o_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_new_head: got %h valid %b required %h valid 1",
               bus.out, bus.o_valid, mk_row(1, 5));
    end
    drive('0, '0, 1'b1);
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_valid, bus.o_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_end: got valid/err=%b required 00", {bus.o_valid, bus.o_err});
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 5; r++) begin
      drive(8'hFF, mk_row(r, 6), 1'b0);
      tick();
    end
    drive(8'hFF, mk_row(9, 6), 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({bus.o_valid, bus.o_full, bus.o_ready, bus.o_err} !== 4'b0010) begin
      n_bad++;
      $display("FAIL rstmid_flags: got v/f/r/e=%b required 0010",
               {bus.o_valid, bus.o_full, bus.o_ready, bus.o_err});
    end
    drive(8'hFF, mk_row(0, 7), 1'b0);
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if (bus.out !== mk_row(0, 7) || bus.o_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_first: got %h valid %b required %h valid 1",
               bus.out, bus.o_valid, mk_row(0, 7));
    end
    drive('0, '0, 1'b1);
    tick();
    drive('0, '0, 1'b0);
    n_cmp++;
    if (bus.o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_drain: got valid %b required 0", bus.o_valid);
    end
  endtask

  task automatic test_wrap();
    logic saw_err;
    logic saw_full;
    saw_err  = 1'b0;
    saw_full = 1'b0;
    for (int t = 0; t < 203; t++) begin
      drive((t < 200) ? 8'hFF : 8'h00, mk_row(t, 8), (t >= 3));
      if (t >= 3) begin
        n_cmp++;
        if (bus.out !== mk_row(t - 3, 8) || bus.o_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL wrap_row%0d: got %h valid %b required %h valid 1",
                   t - 3, bus.out, bus.o_valid, mk_row(t - 3, 8));
        end
      end
      tick();
      saw_err  = saw_err | bus.o_err;
      saw_full = saw_full | bus.o_full;
    end
    drive('0, '0, 1'b0);
    n_cmp++;
    if ({saw_err, saw_full, bus.o_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL wrap_flags: got err/full/valid=%b required 000",
               {saw_err, saw_full, bus.o_valid});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    drive('0, '0, 1'b0);
    test_reset();
    test_skewed_fill();
    test_fill_capacity();
    test_full_concurrent();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
